// File: rtl/writeback_stage.sv
// WB stage: latches the MEM/WB register, selects and aligns the writeback value,
// drives the register-file write port, and keeps the retire counter and halt flag.
module writeback_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic [XLEN-1:0]      mem_pc_plus4,
    input  logic                 mem_is_halt,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      rd_din,
    output logic                 write_enable,
    output logic                 misaligned,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                 valid_q;
    logic                 reg_write_q;
    logic [4:0]           rd_q;
    logic [1:0]           wb_sel_q;
    logic [2:0]           funct3_q;
    logic [XLEN-1:0]      alu_q;
    logic [XLEN-1:0]      rdata_q;
    logic [XLEN-1:0]      pc4_q;
    logic                 is_halt_q;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 halted_q, halted_d;

    logic [1:0]           off;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [XLEN-1:0]      load_data;
    logic                 is_load;
    logic                 retire;

    // Only the valid bit is cleared by a flush; the payload is don't-care for a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            is_halt_q   <= 1'b0;
            instret_q   <= '0;
            halted_q    <= 1'b0;
        end else begin
            instret_q <= instret_d;
            halted_q  <= halted_d;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q     <= mem_valid;
                reg_write_q <= mem_reg_write;
                rd_q        <= mem_rd;
                wb_sel_q    <= mem_wb_sel;
                funct3_q    <= mem_funct3;
                alu_q       <= mem_alu_result;
                rdata_q     <= mem_rdata;
                pc4_q       <= mem_pc_plus4;
                is_halt_q   <= mem_is_halt;
            end
        end
    end

    assign retire    = valid_q && !halted_q && !stall;
    assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    assign halted_d  = halted_q || (valid_q && is_halt_q && !stall);

    assign off     = alu_q[1:0];
    assign is_load = (wb_sel_q == 2'd1);

    always_comb begin
        byte_sel = rdata_q[7:0];
        case (off)
            2'd0: byte_sel = rdata_q[7:0];
            2'd1: byte_sel = rdata_q[15:8];
            2'd2: byte_sel = rdata_q[23:16];
            2'd3: byte_sel = rdata_q[31:24];
            default: byte_sel = rdata_q[7:0];
        endcase
    end

    assign half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_data = rdata_q;
        case (funct3_q)
            F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   load_data = rdata_q;
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        rd_din = alu_q;
        case (wb_sel_q)
            2'd1:    rd_din = load_data;
            2'd2:    rd_din = pc4_q;
            default: rd_din = alu_q;
        endcase
    end

    assign misaligned = valid_q && is_load &&
                        ((((funct3_q == F3_LH) || (funct3_q == F3_LHU)) && off[0]) ||
                         ((funct3_q == F3_LW) && (off != 2'd0)));

    // Same gated triple doubles as the EX-stage forwarding source.
    assign write_enable = valid_q && reg_write_q && (rd_q != 5'd0) && !misaligned && !halted_q;
    assign rd           = rd_q;
    assign instret      = instret_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a spec-level model checked every negedge,
// plus literal expectations at the points worked out by hand.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, mem_valid, mem_reg_write, mem_is_halt;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_rdata, mem_pc_plus4;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        write_enable, misaligned, halted;
    logic [63:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_pc_plus4(mem_pc_plus4), .mem_is_halt(mem_is_halt),
        .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
        .misaligned(misaligned), .instret(instret), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: what the WB slot holds, and the architectural counters.
    logic        m_valid, m_rw, m_halt, m_halted;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_rdata, m_pc;
    logic [63:0] m_instret;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 0; m_rw = 0; m_halt = 0; m_halted = 0; m_rd = 0; m_sel = 0;
            m_f3 = 0; m_alu = 0; m_rdata = 0; m_pc = 0; m_instret = 0;
        end else begin
            if (m_valid && !m_halted && !stall) m_instret = m_instret + 1;
            if (m_valid && m_halt && !stall) m_halted = 1;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd; m_sel = mem_wb_sel;
                m_f3 = mem_funct3; m_alu = mem_alu_result; m_rdata = mem_rdata;
                m_pc = mem_pc_plus4; m_halt = mem_is_halt;
            end
        end
    end

    function automatic logic exp_mis();
        int o = int'(m_alu % 4);
        return m_valid && m_sel == 1 &&
               (((m_f3 == 1 || m_f3 == 5) && (o % 2 == 1)) || (m_f3 == 2 && o != 0));
    endfunction

    function automatic logic [31:0] exp_din();
        int o = int'(m_alu % 4);
        logic [31:0] b = (m_rdata >> (8 * o)) & 32'hFF;
        logic [31:0] h = (m_rdata >> (16 * (o / 2))) & 32'hFFFF;
        if (m_sel == 2) return m_pc;
        if (m_sel != 1) return m_alu;
        case (m_f3)
            3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4: return b;
            3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5: return h;
            default: return m_rdata;
        endcase
    endfunction

    function automatic logic exp_we();
        return m_valid && m_rw && m_rd != 0 && !exp_mis() && !m_halted;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("model_we", {63'd0, write_enable}, {63'd0, exp_we()});
            chk("model_mis", {63'd0, misaligned}, {63'd0, exp_mis()});
            chk("model_instret", instret, m_instret);
            chk("model_halted", {63'd0, halted}, {63'd0, m_halted});
            if (m_valid) begin
                chk("model_rd", {59'd0, rd}, {59'd0, m_rd});
                chk("model_din", {32'd0, rd_din}, {32'd0, exp_din()});
            end
        end
    end

    task automatic send(input logic v, input logic rw, input logic [4:0] r, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [31:0] pc, input logic h);
        stall = 0; flush = 0;
        mem_valid = v; mem_reg_write = rw; mem_rd = r; mem_wb_sel = sel; mem_funct3 = f3;
        mem_alu_result = alu; mem_rdata = rdat; mem_pc_plus4 = pc; mem_is_halt = h;
        @(posedge clk); #1;
    endtask

    task automatic bubble();
        send(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
    endtask

    initial begin
        reset = 0; stall = 0; flush = 0; mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
        mem_wb_sel = 0; mem_funct3 = 0; mem_alu_result = 0; mem_rdata = 0;
        mem_pc_plus4 = 0; mem_is_halt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {63'd0, write_enable}, 64'd0);
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_din", {32'd0, rd_din}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        reset = 1;

        // ALU and PC+4 writebacks
        send(1, 1, 5, 0, 0, 32'h1234, 0, 32'h40, 0);
        chk("alu_we", {63'd0, write_enable}, 64'd1);
        chk("alu_rd", {59'd0, rd}, 64'd5);
        chk("alu_din", {32'd0, rd_din}, 64'h1234);
        send(1, 1, 1, 2, 0, 32'h9, 0, 32'h104, 0);
        chk("pc4_din", {32'd0, rd_din}, 64'h104);
        send(1, 1, 2, 3, 0, 32'h77, 0, 32'h108, 0);
        chk("sel3_din", {32'd0, rd_din}, 64'h77);

        // Loads
        send(1, 1, 10, 1, 3'b000, 32'h1003, 32'h80FF7F01, 0, 0);
        chk("lb_din", {32'd0, rd_din}, 64'hFFFFFF80);
        send(1, 1, 10, 1, 3'b100, 32'h1001, 32'h80FF7F01, 0, 0);
        chk("lbu_din", {32'd0, rd_din}, 64'h7F);
        send(1, 1, 10, 1, 3'b001, 32'h1002, 32'h80FF7F01, 0, 0);
        chk("lh_din", {32'd0, rd_din}, 64'hFFFF80FF);
        send(1, 1, 10, 1, 3'b101, 32'h1000, 32'h80FF7F01, 0, 0);
        chk("lhu_din", {32'd0, rd_din}, 64'h7F01);
        send(1, 1, 10, 1, 3'b010, 32'h1002, 32'h80FF7F01, 0, 0);
        chk("lw_mis", {63'd0, misaligned}, 64'd1);
        chk("lw_mis_we", {63'd0, write_enable}, 64'd0);
        send(1, 1, 10, 1, 3'b101, 32'h1003, 32'h80FF7F01, 0, 0);
        chk("lhu_mis", {63'd0, misaligned}, 64'd1);
        send(1, 1, 10, 1, 3'b010, 32'h1000, 32'h80FF7F01, 0, 0);
        chk("lw_din", {32'd0, rd_din}, 64'h80FF7F01);
        bubble();

        // Write to x0 suppressed but retired
        do_reset();
        send(1, 1, 0, 0, 0, 32'hDEAD, 0, 0, 0);
        chk("x0_we", {63'd0, write_enable}, 64'd0);
        bubble();
        chk("x0_instret", instret, 64'd1);

        // Stall holds and counts once; stall+flush makes a bubble
        do_reset();
        send(1, 1, 6, 0, 0, 32'hABCD, 0, 0, 0);
        stall = 1; mem_valid = 1; mem_rd = 9; mem_alu_result = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_din", {32'd0, rd_din}, 64'hABCD);
            chk("stall_we", {63'd0, write_enable}, 64'd1);
            chk("stall_instret", instret, 64'd0);
        end
        bubble();
        chk("stall_once", instret, 64'd1);
        send(1, 1, 7, 0, 0, 32'h42, 0, 0, 0);
        stall = 1; flush = 1;
        @(posedge clk); #1;
        chk("sf_we", {63'd0, write_enable}, 64'd0);
        chk("sf_instret", instret, 64'd1);
        bubble();

        // Halt after 10 instructions
        do_reset();
        for (int i = 1; i <= 10; i++) send(1, 1, 5'(i), 0, 0, 32'(i * 3), 0, 0, 0);
        send(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("pre_halt_instret", instret, 64'd10);
        send(1, 1, 3, 0, 0, 32'h99, 0, 0, 0);
        chk("halt_instret", instret, 64'd11);
        chk("halt_flag", {63'd0, halted}, 64'd1);
        chk("halt_we", {63'd0, write_enable}, 64'd0);
        send(1, 1, 4, 0, 0, 32'h98, 0, 0, 0);
        send(1, 1, 4, 0, 0, 32'h97, 0, 0, 0);
        chk("halt_frozen", instret, 64'd11);
        #2 reset = 0;
        #1;
        chk("arst_halted", {63'd0, halted}, 64'd0);
        chk("arst_instret0", instret, 64'd0);
        @(posedge clk); #1;
        reset = 1;

        // Async reset mid-write
        send(1, 1, 8, 0, 0, 32'h55, 0, 0, 0);
        send(1, 1, 9, 0, 0, 32'h66, 0, 0, 0);
        chk("pre_arst_we", {63'd0, write_enable}, 64'd1);
        #2 reset = 0;
        #1;
        chk("arst_we", {63'd0, write_enable}, 64'd0);
        chk("arst_instret", instret, 64'd0);
        chk("arst_halted2", {63'd0, halted}, 64'd0);
        @(posedge clk); #1;
        reset = 1;
        bubble();
        bubble();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
